tmp3_scheduler: RTL and testbench
=================================

# tmp3_scheduler

Sequencing controller for the Pmod TMP3 interface. It sits between system logic (or a tester) and the TMP3 driver. It owns the driver's configuration lines, serialises configuration, limit and hysteresis writes and periodic temperature reads onto the single driver port, and keeps last/min/max readings with timeout detection.

## Interface
- `PERIOD`, 25_000_000: clock cycles between automatic samples; must be ≥ 2.
- `TIMEOUT`, 2_000_000: max cycles to wait for driver completion per transaction.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enable` in 1: periodic sampling on (level).
- `sample_now` in 1: one-cycle request for an immediate read.
- `cfg_req` in 1: one-cycle request; latches `cfg_in`.
- `cfg_in` in 6: {interrupt_mode, alert_polarity, fault_queue[1:0], resolution[1:0]}.
- `shutdown_in` in 1: requested shutdown level; applied like a config field.
- `lim_req` / `hyst_req` in 1 each: one-cycle requests; each latches `thr_in`.
- `thr_in` in 9: threshold, two's complement, 0.5 °C LSB.
- `clr_minmax` in 1: one-cycle clear of min/max.
- `resolution` out 2, `fault_queue` out 2, `alert_polarity` out 1, `interrupt_mode` out 1, `shutdown` out 1: driver config levels.
- `update` out 1: one-cycle read/config-push pulse to the driver.
- `write_temperature` out 1: one-cycle threshold write pulse.
- `write_hyst_nLim` out 1: 1 = hysteresis, 0 = limit; stable while a write is in flight.
- `temperature_i` out 9: threshold value to the driver.
- `busy` in 1, `valid_o` in 1, `temperature_o` in 12: driver status and result (12-bit two's complement, 0.0625 °C LSB).
- `temp_last`, `temp_min`, `temp_max` out 12: readings.
- `sample_valid` out 1: one-cycle pulse when `temp_last` updates.
- `minmax_valid` out 1: min/max hold at least one sample.
- `timeout_err` out 1: sticky; cleared by reset only.
- `overrun` out 1: sticky; a period tick arrived while a sample was still pending.
- `idle` out 1: FSM in IDLE with no pending requests.

## Operation
- Reset: all outputs 0, `idle`=1, all pending flags 0, period counter 0.
- Pending flags: cfg, lim, hyst, sample. Set by the request pulse or period tick; cleared when that transaction is issued. A repeated request while pending overwrites the latched data and stays a single pending request.
- Arbitration in IDLE, fixed priority: cfg > lim > hyst > sample.
- FSM states: IDLE, CFG_APPLY, CFG_PUSH, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- CFG_APPLY: drive config outputs from the latch (incl. `shutdown`). Next cycle CFG_PUSH issues `update` and waits as RD_WAIT does. Any `valid_o` data is captured as a sample.
- WR_ISSUE: set `temperature_i` and `write_hyst_nLim`, pulse `write_temperature`, go to WR_WAIT. Done when `busy` has been seen high and then low.
- RD_ISSUE: pulse `update`, go to RD_WAIT. Done on `valid_o`.
- Issue states pulse only when `busy`=0; otherwise they hold.
- Sample capture on `valid_o`:
  - load `temp_last` and pulse `sample_valid`.
  - If `minmax_valid`=0: load min and max, then set `minmax_valid`.
  - Else: signed compare and update min/max.
- `clr_minmax` clears `minmax_valid`; min/max are reloaded on the next sample. If it coincides with `valid_o`, that sample reloads both.
- Timeout: wait states count cycles. At TIMEOUT: set `timeout_err`, return to IDLE, leave readings unchanged.
- `shutdown`=1: periodic ticks are suppressed; `sample_now` is still served. The driver is then expected to issue a one-shot read.
- Period counter:
  - Counts while `enable`=1 and wraps at PERIOD-1, setting sample pending.
  - Tick with sample already pending sets `overrun`.
  - `enable`=0 clears the counter.

## Timing
- Request pulse at cycle N, FSM idle, `busy`=0 → `update` (or `write_temperature`) at N+2. Config: `update` at N+3.
- `valid_o` at cycle M → `temp_last`/`sample_valid` at M+1, min/max at M+1, FSM in IDLE at M+1.
- Config outputs change only in CFG_APPLY; they never change while a driver transaction is in flight.
- Reset mid-transaction aborts immediately. A late `valid_o` in IDLE is ignored.
- `enable` rising: first automatic sample after PERIOD cycles.

## Structure
- Shared header `tmp3_defs.vh`: FSM state encodings, `cfg_in` bit positions, temperature widths (12/9). The TMP3 driver also uses this header.
- Sub-module `tmp3_period_timer`: PERIOD counter with enable/clear and tick output. Everything else lives in one module.

## Test plan
- Set `enable`=1, PERIOD=100, driver model returns 0x190 (25 °C) after 20 cycles → `update` every 100 cycles; `temp_last`=0x190; min=max=0x190.
- Samples 0x190, 0xF00 (−16 °C), 0x7F0 → min=0xF00, max=0x7F0 (signed). `clr_minmax` then 0x010 → min=max=0x010.
- `cfg_req`, `lim_req` (0x050), `hyst_req` (0x04A) and `sample_now` in one cycle → order is config push, lim write (`write_hyst_nLim`=0), hyst write (=1), read.
- Driver never asserts `valid_o`, TIMEOUT=50 → `timeout_err`=1 at cycle 50 of wait, FSM IDLE, `temp_last` unchanged.
- Read stalled past a period tick and a second tick → `overrun`=1, only one extra read issued.
- `rst` low during RD_WAIT → all outputs to reset values; a later `valid_o` leaves `temp_last`=0.

Source files
------------

// File: rtl/tmp3_scheduler_pkg.sv
// ============================================================================
// tmp3_scheduler_pkg: shared TMP3 state encodings, config layout and widths.
// Rev 1.0
// ============================================================================
`default_nettype none

package tmp3_scheduler_pkg;

    localparam int TEMP_W = 12;
    localparam int THR_W  = 9;
    localparam int CFG_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG_APPLY = 3'd1,
        ST_CFG_PUSH  = 3'd2,
        ST_WR_ISSUE  = 3'd3,
        ST_WR_WAIT   = 3'd4,
        ST_RD_ISSUE  = 3'd5,
        ST_RD_WAIT   = 3'd6
    } state_t;

    // Field order matches the cfg_in bus, MSB first.
    typedef struct packed {
        logic       interrupt_mode;
        logic       alert_polarity;
        logic [1:0] fault_queue;
        logic [1:0] resolution;
    } cfg_t;

    function automatic logic temp_lt(input logic [TEMP_W-1:0] a,
                                     input logic [TEMP_W-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tmp3_period_timer.sv
// ============================================================================
// tmp3_period_timer: free-running PERIOD counter, cleared while disabled.
// Rev 1.0
// ============================================================================
`default_nettype none

module tmp3_period_timer #(
    parameter int PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tick_o
);

    localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tmp3_scheduler.sv
// ============================================================================
// tmp3_scheduler: serialises config/threshold writes and reads onto the TMP3 driver.
// Rev 1.0
// ============================================================================
`default_nettype none

module tmp3_scheduler
    import tmp3_scheduler_pkg::*;
#(
    parameter int PERIOD  = 25_000_000,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_now,
    input  logic              cfg_req,
    input  logic [CFG_W-1:0]  cfg_in,
    input  logic              shutdown_in,
    input  logic              lim_req,
    input  logic              hyst_req,
    input  logic [THR_W-1:0]  thr_in,
    input  logic              clr_minmax,
    output logic [1:0]        resolution,
    output logic [1:0]        fault_queue,
    output logic              alert_polarity,
    output logic              interrupt_mode,
    output logic              shutdown,
    output logic              update,
    output logic              write_temperature,
    output logic              write_hyst_nLim,
    output logic [THR_W-1:0]  temperature_i,
    input  logic              busy,
    input  logic              valid_o,
    input  logic [TEMP_W-1:0] temperature_o,
    output logic [TEMP_W-1:0] temp_last,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max,
    output logic              sample_valid,
    output logic              minmax_valid,
    output logic              timeout_err,
    output logic              overrun,
    output logic              idle
);

    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              cfg_pend_q, cfg_pend_d;
    logic              lim_pend_q, lim_pend_d;
    logic              hyst_pend_q, hyst_pend_d;
    logic              smp_pend_q, smp_pend_d;
    cfg_t              cfg_lat_q, cfg_lat_d;
    logic              sd_lat_q, sd_lat_d;
    logic [THR_W-1:0]  lim_lat_q, lim_lat_d;
    logic [THR_W-1:0]  hyst_lat_q, hyst_lat_d;
    cfg_t              cfg_out_q, cfg_out_d;
    logic              shutdown_q, shutdown_d;
    logic [THR_W-1:0]  thr_q, thr_d;
    logic              hyst_sel_q, hyst_sel_d;
    logic              seen_busy_q, seen_busy_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TEMP_W-1:0] last_q, last_d;
    logic [TEMP_W-1:0] min_q, min_d;
    logic [TEMP_W-1:0] max_q, max_d;
    logic              smp_valid_q, smp_valid_d;
    logic              mm_valid_q, mm_valid_d;
    logic              to_err_q, to_err_d;
    logic              overrun_q, overrun_d;

    logic              period_tick;
    logic              tick_eff;
    logic              capture;

    tmp3_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .tick_o   (period_tick)
    );

    // Shutdown mode relies on the driver's own one-shot reads.
    assign tick_eff = period_tick && !shutdown_q;

    always_comb begin
        state_d           = state_q;
        cfg_pend_d        = cfg_pend_q;
        lim_pend_d        = lim_pend_q;
        hyst_pend_d       = hyst_pend_q;
        smp_pend_d        = smp_pend_q;
        cfg_lat_d         = cfg_lat_q;
        sd_lat_d          = sd_lat_q;
        lim_lat_d         = lim_lat_q;
        hyst_lat_d        = hyst_lat_q;
        cfg_out_d         = cfg_out_q;
        shutdown_d        = shutdown_q;
        thr_d             = thr_q;
        hyst_sel_d        = hyst_sel_q;
        seen_busy_d       = seen_busy_q;
        to_cnt_d          = '0;
        last_d            = last_q;
        min_d             = min_q;
        max_d             = max_q;
        smp_valid_d       = 1'b0;
        mm_valid_d        = mm_valid_q;
        to_err_d          = to_err_q;
        overrun_d         = overrun_q;
        update            = 1'b0;
        write_temperature = 1'b0;
        capture           = 1'b0;

        if (cfg_req) begin
            cfg_lat_d = cfg_t'(cfg_in);
            sd_lat_d  = shutdown_in;
        end
        if (lim_req) begin
            lim_lat_d = thr_in;
        end
        if (hyst_req) begin
            hyst_lat_d = thr_in;
        end
        if (tick_eff && smp_pend_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_pend_q) begin
                    cfg_pend_d = 1'b0;
                    state_d    = ST_CFG_APPLY;
                end else if (lim_pend_q) begin
                    lim_pend_d = 1'b0;
                    thr_d      = lim_lat_q;
                    hyst_sel_d = 1'b0;
                    state_d    = ST_WR_ISSUE;
                end else if (hyst_pend_q) begin
                    hyst_pend_d = 1'b0;
                    thr_d       = hyst_lat_q;
                    hyst_sel_d  = 1'b1;
                    state_d     = ST_WR_ISSUE;
                end else if (smp_pend_q) begin
                    smp_pend_d = 1'b0;
                    state_d    = ST_RD_ISSUE;
                end
            end
            ST_CFG_APPLY: begin
                cfg_out_d  = cfg_lat_q;
                shutdown_d = sd_lat_q;
                state_d    = ST_CFG_PUSH;
            end
            ST_CFG_PUSH, ST_RD_ISSUE: begin
                if (!busy) begin
                    update  = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_ISSUE: begin
                seen_busy_d = 1'b0;
                if (!busy) begin
                    write_temperature = 1'b1;
                    state_d           = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (seen_busy_q && !busy) begin
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (busy) begin
                        seen_busy_d = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (valid_o) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New requests win over a same-cycle grant so none is lost.
        if (cfg_req) begin
            cfg_pend_d = 1'b1;
        end
        if (lim_req) begin
            lim_pend_d = 1'b1;
        end
        if (hyst_req) begin
            hyst_pend_d = 1'b1;
        end
        if (sample_now || tick_eff) begin
            smp_pend_d = 1'b1;
        end

        if (clr_minmax) begin
            mm_valid_d = 1'b0;
        end
        if (capture) begin
            last_d      = temperature_o;
            smp_valid_d = 1'b1;
            mm_valid_d  = 1'b1;
            if (!mm_valid_q || clr_minmax) begin
                min_d = temperature_o;
                max_d = temperature_o;
            end else begin
                if (temp_lt(temperature_o, min_q)) begin
                    min_d = temperature_o;
                end
                if (temp_lt(max_q, temperature_o)) begin
                    max_d = temperature_o;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_pend_q  <= 1'b0;
            lim_pend_q  <= 1'b0;
            hyst_pend_q <= 1'b0;
            smp_pend_q  <= 1'b0;
            cfg_lat_q   <= '0;
            sd_lat_q    <= 1'b0;
            lim_lat_q   <= '0;
            hyst_lat_q  <= '0;
            cfg_out_q   <= '0;
            shutdown_q  <= 1'b0;
            thr_q       <= '0;
            hyst_sel_q  <= 1'b0;
            seen_busy_q <= 1'b0;
            to_cnt_q    <= '0;
            last_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            smp_valid_q <= 1'b0;
            mm_valid_q  <= 1'b0;
            to_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cfg_pend_q  <= cfg_pend_d;
            lim_pend_q  <= lim_pend_d;
            hyst_pend_q <= hyst_pend_d;
            smp_pend_q  <= smp_pend_d;
            cfg_lat_q   <= cfg_lat_d;
            sd_lat_q    <= sd_lat_d;
            lim_lat_q   <= lim_lat_d;
            hyst_lat_q  <= hyst_lat_d;
            cfg_out_q   <= cfg_out_d;
            shutdown_q  <= shutdown_d;
            thr_q       <= thr_d;
            hyst_sel_q  <= hyst_sel_d;
            seen_busy_q <= seen_busy_d;
            to_cnt_q    <= to_cnt_d;
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            smp_valid_q <= smp_valid_d;
            mm_valid_q  <= mm_valid_d;
            to_err_q    <= to_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign resolution      = cfg_out_q.resolution;
    assign fault_queue     = cfg_out_q.fault_queue;
    assign alert_polarity  = cfg_out_q.alert_polarity;
    assign interrupt_mode  = cfg_out_q.interrupt_mode;
    assign shutdown        = shutdown_q;
    assign write_hyst_nLim = hyst_sel_q;
    assign temperature_i   = thr_q;
    assign temp_last       = last_q;
    assign temp_min        = min_q;
    assign temp_max        = max_q;
    assign sample_valid    = smp_valid_q;
    assign minmax_valid    = mm_valid_q;
    assign timeout_err     = to_err_q;
    assign overrun         = overrun_q;
    assign idle            = (state_q == ST_IDLE) && !cfg_pend_q && !lim_pend_q
                             && !hyst_pend_q && !smp_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_tmp3_scheduler.sv
// ============================================================================
// tb_tmp3_scheduler: directed bench with a simple TMP3 driver model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tmp3_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        sample_now = 1'b0;
    logic        cfg_req = 1'b0;
    logic [5:0]  cfg_in = '0;
    logic        shutdown_in = 1'b0;
    logic        lim_req = 1'b0;
    logic        hyst_req = 1'b0;
    logic [8:0]  thr_in = '0;
    logic        clr_minmax = 1'b0;
    logic [1:0]  resolution, fault_queue;
    logic        alert_polarity, interrupt_mode, shutdown;
    logic        update, write_temperature, write_hyst_nLim;
    logic [8:0]  temperature_i;
    wire         busy;
    logic        valid_o = 1'b0;
    logic [11:0] temperature_o = '0;
    logic [11:0] temp_last, temp_min, temp_max;
    logic        sample_valid, minmax_valid, timeout_err, overrun, idle;

    tmp3_scheduler #(
        .PERIOD  (100),
        .TIMEOUT (50)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .sample_now        (sample_now),
        .cfg_req           (cfg_req),
        .cfg_in            (cfg_in),
        .shutdown_in       (shutdown_in),
        .lim_req           (lim_req),
        .hyst_req          (hyst_req),
        .thr_in            (thr_in),
        .clr_minmax        (clr_minmax),
        .resolution        (resolution),
        .fault_queue       (fault_queue),
        .alert_polarity    (alert_polarity),
        .interrupt_mode    (interrupt_mode),
        .shutdown          (shutdown),
        .update            (update),
        .write_temperature (write_temperature),
        .write_hyst_nLim   (write_hyst_nLim),
        .temperature_i     (temperature_i),
        .busy              (busy),
        .valid_o           (valid_o),
        .temperature_o     (temperature_o),
        .temp_last         (temp_last),
        .temp_min          (temp_min),
        .temp_max          (temp_max),
        .sample_valid      (sample_valid),
        .minmax_valid      (minmax_valid),
        .timeout_err       (timeout_err),
        .overrun           (overrun),
        .idle              (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver model: busy one cycle after a pulse; reads end with valid_o.
    int          drv_lat = 20;
    bit          drv_respond = 1'b1;
    bit          drv_hold = 1'b0;
    logic [11:0] drv_val = 12'h190;
    bit          drv_busy = 1'b0;
    bit          drv_started = 1'b0;
    bit          drv_is_rd = 1'b0;
    int          drv_cnt = 0;
    int          n_upd = 0;
    int          ev_q[$];
    int          upd_t[$];

    assign busy = drv_hold | drv_busy;

    always @(negedge clk) begin
        bit upd, wr;
        upd     = update;
        wr      = write_temperature;
        valid_o = 1'b0;
        if (drv_started) begin
            drv_started = 1'b0;
            drv_busy    = 1'b1;
            drv_cnt     = drv_is_rd ? drv_lat : 3;
        end else if (drv_cnt > 0) begin
            drv_cnt = drv_cnt - 1;
            if (drv_cnt == 0) begin
                drv_busy = 1'b0;
                if (drv_is_rd && drv_respond) begin
                    valid_o       = 1'b1;
                    temperature_o = drv_val;
                end
            end
        end
        if (upd || wr) begin
            drv_started = 1'b1;
            drv_is_rd   = upd;
            if (upd) begin
                ev_q.push_back(32'h1000);
                upd_t.push_back(cyc);
                n_upd = n_upd + 1;
            end else begin
                ev_q.push_back(((2 + int'(write_hyst_nLim)) << 12) | int'(temperature_i));
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!idle && n < 500);
        check(name, 32'(idle), 32'd1);
    endtask

    task automatic wait_sample(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 200);
        check(name, 32'(sample_valid), 32'd1);
    endtask

    task automatic pulse_sample();
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
    endtask

    typedef struct {
        logic [11:0] val;
        bit          clr;
        logic [11:0] e_last;
        logic [11:0] e_min;
        logic [11:0] e_max;
    } vec_t;

    vec_t vec[6];

    initial begin
        int base, n, t_en, d0, d1, d2;

        vec[0] = '{12'hF00, 1'b0, 12'hF00, 12'hF00, 12'h190};
        vec[1] = '{12'h7F0, 1'b0, 12'h7F0, 12'hF00, 12'h7F0};
        vec[2] = '{12'h010, 1'b1, 12'h010, 12'h010, 12'h010};
        vec[3] = '{12'h800, 1'b0, 12'h800, 12'h800, 12'h010};
        vec[4] = '{12'h7FF, 1'b0, 12'h7FF, 12'h800, 12'h7FF};
        vec[5] = '{12'hFFF, 1'b0, 12'hFFF, 12'h800, 12'h7FF};

        repeat (3) step();
        check("reset idle", 32'(idle), 32'd1);
        check("reset strobes", {29'd0, update, write_temperature, sample_valid}, 32'd0);
        check("reset flags", {28'd0, minmax_valid, timeout_err, overrun, shutdown}, 32'd0);
        check("reset cfg", {26'd0, interrupt_mode, alert_polarity, fault_queue, resolution}, 32'd0);
        check("reset readings", 32'(temp_last) | 32'(temp_min) | 32'(temp_max), 32'd0);
        rst = 1'b1;
        step();

        // sample_now at N -> update at N+2
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        check("rd N+1 update", 32'(update), 32'd0);
        step();
        check("rd N+2 update", 32'(update), 32'd1);
        wait_sample("first sample");
        check("first last", 32'(temp_last), 32'h190);
        check("first idle", 32'(idle), 32'd1);

        // Periodic sampling
        t_en   = cyc;
        base   = upd_t.size();
        enable = 1'b1;
        repeat (320) step();
        enable = 1'b0;
        wait_idle("periodic idle");
        check("periodic count", 32'(upd_t.size() - base), 32'd3);
        d0 = (upd_t.size() > base)     ? upd_t[base] - t_en           : -1;
        d1 = (upd_t.size() > base + 1) ? upd_t[base+1] - upd_t[base]   : -1;
        d2 = (upd_t.size() > base + 2) ? upd_t[base+2] - upd_t[base+1] : -1;
        check("periodic first", 32'(d0), 32'd101);
        check("periodic gap1", 32'(d1), 32'd100);
        check("periodic gap2", 32'(d2), 32'd100);
        check("periodic minmax", {8'd0, temp_min, temp_max}, {8'd0, 12'h190, 12'h190});

        for (int i = 0; i < 6; i++) begin
            if (vec[i].clr) begin
                clr_minmax = 1'b1;
                step();
                clr_minmax = 1'b0;
                check($sformatf("vec%0d cleared", i), 32'(minmax_valid), 32'd0);
            end
            drv_val = vec[i].val;
            pulse_sample();
            wait_sample($sformatf("vec%0d sample", i));
            check($sformatf("vec%0d last", i), 32'(temp_last), 32'(vec[i].e_last));
            check($sformatf("vec%0d min", i), 32'(temp_min), 32'(vec[i].e_min));
            check($sformatf("vec%0d max", i), 32'(temp_max), 32'(vec[i].e_max));
            check($sformatf("vec%0d mv", i), 32'(minmax_valid), 32'd1);
        end

        // clr_minmax in the same cycle as valid_o reloads both
        drv_val = 12'h0C0;
        pulse_sample();
        n = 0;
        while (!valid_o && n < 200) begin
            step();
            n++;
        end
        check("coincide valid seen", 32'(valid_o), 32'd1);
        clr_minmax = 1'b1;
        step();
        clr_minmax = 1'b0;
        check("coincide min/max", {8'd0, temp_min, temp_max}, {8'd0, 12'h0C0, 12'h0C0});
        check("coincide mv", 32'(minmax_valid), 32'd1);

        // Arbitration order and config timing (update at N+3)
        drv_val     = 12'h100;
        base        = ev_q.size();
        cfg_in      = 6'b101101;
        cfg_req     = 1'b1;
        lim_req     = 1'b1;
        thr_in      = 9'h050;
        sample_now  = 1'b1;
        step();
        cfg_req     = 1'b0;
        lim_req     = 1'b0;
        sample_now  = 1'b0;
        hyst_req    = 1'b1;
        thr_in      = 9'h04A;
        step();
        hyst_req    = 1'b0;
        check("cfg N+2 update", 32'(update), 32'd0);
        check("cfg N+2 old cfg", {26'd0, interrupt_mode, alert_polarity, fault_queue, resolution}, 32'd0);
        step();
        check("cfg N+3 update", 32'(update), 32'd1);
        check("cfg N+3 new cfg", {26'd0, interrupt_mode, alert_polarity, fault_queue, resolution}, 32'h2D);
        wait_idle("order idle");
        check("order count", 32'(ev_q.size() - base), 32'd4);
        check("order 0 cfg push", (ev_q.size() > base)     ? 32'(ev_q[base])   : 32'hDEAD, 32'h1000);
        check("order 1 lim", (ev_q.size() > base + 1)      ? 32'(ev_q[base+1]) : 32'hDEAD, 32'h2050);
        check("order 2 hyst", (ev_q.size() > base + 2)     ? 32'(ev_q[base+2]) : 32'hDEAD, 32'h304A);
        check("order 3 read", (ev_q.size() > base + 3)     ? 32'(ev_q[base+3]) : 32'hDEAD, 32'h1000);

        // Shutdown suppresses periodic ticks but serves sample_now
        drv_val     = 12'h155;
        cfg_req     = 1'b1;
        shutdown_in = 1'b1;
        step();
        cfg_req     = 1'b0;
        wait_idle("sd cfg idle");
        check("sd level", 32'(shutdown), 32'd1);
        base   = n_upd;
        enable = 1'b1;
        repeat (250) step();
        check("sd no periodic", 32'(n_upd - base), 32'd0);
        pulse_sample();
        wait_sample("sd sample_now");
        check("sd read count", 32'(n_upd - base), 32'd1);
        enable      = 1'b0;
        cfg_req     = 1'b1;
        shutdown_in = 1'b0;
        step();
        cfg_req     = 1'b0;
        wait_idle("sd off idle");
        check("sd off level", 32'(shutdown), 32'd0);

        // Timeout: no valid_o from the driver
        drv_respond = 1'b0;
        pulse_sample();
        n = 0;
        while (!update && n < 10) begin
            step();
            n++;
        end
        check("to update seen", 32'(update), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!timeout_err && n < 200);
        check("to latency", 32'(n), 32'd51);
        check("to idle", 32'(idle), 32'd1);
        check("to last kept", 32'(temp_last), 32'h155);
        drv_respond = 1'b1;

        // Overrun: read held in issue across two ticks
        drv_val    = 12'h0AA;
        drv_hold   = 1'b1;
        enable     = 1'b1;
        pulse_sample();
        repeat (150) step();
        check("ovr after 1 tick", 32'(overrun), 32'd0);
        repeat (60) step();
        check("ovr after 2 ticks", 32'(overrun), 32'd1);
        enable = 1'b0;
        base   = n_upd;
        @(posedge clk);
        #1;
        drv_hold = 1'b0;
        wait_idle("ovr idle");
        check("ovr reads", 32'(n_upd - base), 32'd2);

        // Reset during RD_WAIT, late valid_o ignored
        drv_val = 12'h2AA;
        pulse_sample();
        n = 0;
        while (!update && n < 10) begin
            step();
            n++;
        end
        check("rst update seen", 32'(update), 32'd1);
        repeat (5) step();
        rst = 1'b0;
        step();
        check("rst idle", 32'(idle), 32'd1);
        check("rst flags", {28'd0, minmax_valid, timeout_err, overrun, shutdown}, 32'd0);
        check("rst cfg", {26'd0, interrupt_mode, alert_polarity, fault_queue, resolution}, 32'd0);
        check("rst readings", 32'(temp_last) | 32'(temp_min) | 32'(temp_max), 32'd0);
        rst = 1'b1;
        n = 0;
        while (!valid_o && n < 40) begin
            step();
            n++;
        end
        check("rst late valid seen", 32'(valid_o), 32'd1);
        step();
        check("rst late sv", 32'(sample_valid), 32'd0);
        check("rst late last", 32'(temp_last), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
